// File: rtl/shift_pkg.sv
// Shared definitions for the shift command queue.
//   SHIFT_W     : operand / result width
//   AMT_W       : shift-amount width
//   shift_req_t : one queued request {num, amt, lr}
package shift_pkg;

  localparam int SHIFT_W = 32;
  localparam int AMT_W   = 5;

  typedef struct packed {
    logic [SHIFT_W-1:0] num;
    logic [AMT_W-1:0]   amt;
    logic               lr;   // 0 = left, 1 = right
  } shift_req_t;

endpackage

// File: rtl/thirtyTwoBitBarrelShifter.sv
// 32-bit logical barrel shifter, zero fill, purely combinational.
// Ports:
//   num        in  [31:0] operand
//   amt        in  [4:0]  shift amount 0..31
//   lr         in  1      0 = shift left, 1 = shift right
//   shiftedNum out [31:0] result (amt = 0 passes num unchanged)
module thirtyTwoBitBarrelShifter
  import shift_pkg::*;
(
  input  logic [SHIFT_W-1:0] num,
  input  logic [AMT_W-1:0]   amt,
  input  logic               lr,
  output logic [SHIFT_W-1:0] shiftedNum
);

  // stage[k] holds the operand after applying amount bits [k-1:0];
  // each stage conditionally shifts by 2**k.
  logic [AMT_W:0][SHIFT_W-1:0] stage;

  assign stage[0] = num;

  for (genvar gi = 0; gi < AMT_W; gi++) begin : g_stage
    assign stage[gi+1] = !amt[gi] ? stage[gi]
                       : lr       ? (stage[gi] >> (1 << gi))
                                  : (stage[gi] << (1 << gi));
  end

  assign shiftedNum = stage[AMT_W];

endmodule

// File: rtl/shift_cmd_queue.sv
// Shift command queue: a DEPTH-entry request FIFO feeding a barrel shifter,
// whose result is captured in a single output register (valid/ready both sides).
// Optional feature: define SHIFT_QUEUE_STATS_EN to add the ops_count port
// (16-bit saturating count of output handshakes).
// Ports:
//   clk        in   sole clock, rising edge
//   reset_n    in   synchronous active-low reset
//   in_valid   in   request valid
//   in_ready   out  queue has room (registered state only)
//   in_num     in   [31:0] operand
//   in_amt     in   [4:0]  shift amount
//   in_lr      in   direction, 0 = left, 1 = right
//   out_valid  out  result register holds valid data
//   out_ready  in   downstream accepts result
//   out_data   out  [31:0] shifted result
//   count      out  [$clog2(DEPTH):0] FIFO occupancy
//   ops_count  out  [15:0] handshake counter (SHIFT_QUEUE_STATS_EN only)
module shift_cmd_queue
  import shift_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SHIFT_W-1:0]       in_num,
  input  logic [AMT_W-1:0]         in_amt,
  input  logic                     in_lr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SHIFT_W-1:0]       out_data,
  output logic [$clog2(DEPTH):0]   count
`ifdef SHIFT_QUEUE_STATS_EN
  ,
  output logic [15:0]              ops_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  shift_req_t           mem [DEPTH];
  logic [AW-1:0]        wr_ptr_reg;
  logic [AW-1:0]        rd_ptr_reg;
  logic [CW-1:0]        count_reg;
  logic                 out_valid_reg;
  logic [SHIFT_W-1:0]   out_data_reg;

  shift_req_t           wr_req;
  shift_req_t           head;
  logic                 head_valid;
  logic                 push;
  logic                 pop;
  logic [SHIFT_W-1:0]   shifted;

  // Depends only on count_reg, so in_ready never sees out_ready. When full
  // with a pop pending, in_ready is still low and the pop simply frees a slot.
  assign in_ready   = (count_reg < CW'(DEPTH));
  assign push       = in_valid && in_ready;

  assign head_valid = (count_reg != '0);
  assign head       = mem[rd_ptr_reg];
  // Load the output register whenever it is empty or being drained this cycle.
  assign pop        = head_valid && (!out_valid_reg || out_ready);

  assign wr_req.num = in_num;
  assign wr_req.amt = in_amt;
  assign wr_req.lr  = in_lr;

  thirtyTwoBitBarrelShifter u_shifter (
    .num        (head.num),
    .amt        (head.amt),
    .lr         (head.lr),
    .shiftedNum (shifted)
  );

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      mem[wr_ptr_reg] <= wr_req;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (pop) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= shifted;
    end else if (out_valid_reg && out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign count     = count_reg;

`ifdef SHIFT_QUEUE_STATS_EN
  logic [15:0] ops_count_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ops_count_reg <= '0;
    end else if (out_valid_reg && out_ready && (ops_count_reg != 16'hFFFF)) begin
      ops_count_reg <= ops_count_reg + 16'd1;
    end
  end

  assign ops_count = ops_count_reg;
`endif

endmodule
